dab_pattern_analyzer: RTL and testbench

Cycle-count demodulator for the dual-active-bridge voltage patterns. It observes the three-level primary and secondary bridge voltages V1/V2, the same signals the DAB pattern generator drives, and measures each full switching period. It reports the period, positive and negative pulse widths of both bridges, and the V1→V2 phase shift, all in clock cycles. It runs alongside the generator as a closed-loop check, and is the front end for measured-waveform telemetry.

---
 rtl/dab_pattern_analyzer.sv | 154 +++++++++++++++
 tb/tb_dab_pattern_analyzer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/dab_pattern_analyzer.sv
// dab_pattern_analyzer: cycle-count demodulator for three-level DAB bridge voltages.
// Measures V1/V2 period and pulse widths plus V1->V2 phase, publishing them with a valid pulse.
module dab_pattern_analyzer #(
    parameter int CNT_W   = 19,
    parameter int TIMEOUT = 500000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic signed [1:0] V1,
    input  logic signed [1:0] V2,
    output logic [CNT_W-1:0]  period1,
    output logic [CNT_W-1:0]  hi1,
    output logic [CNT_W-1:0]  lo1,
    output logic [CNT_W-1:0]  period2,
    output logic [CNT_W-1:0]  hi2,
    output logic [CNT_W-1:0]  lo2,
    output logic [CNT_W-1:0]  phase,
    output logic              valid,
    output logic              locked,
    output logic              timeout
);
    typedef enum logic [1:0] {IDLE, ACQ, TRACK} state_t;
    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t       TO  = cnt_t'(TIMEOUT);
    localparam cnt_t       ONE = cnt_t'(1);
    localparam logic [1:0] POS = 2'b01;
    localparam logic [1:0] NEG = 2'b11;

    state_t     state_q, state_d;
    logic [1:0] v1_q, v1_d, v1_p_q, v2_q, v2_d, v2_p_q, n2_q, n2_d;
    cnt_t       c1_q, c1_d, h1_q, h1_d, l1_q, l1_d;
    cnt_t       c2_q, c2_d, h2_q, h2_d, l2_q, l2_d;
    cnt_t       sp2_q, sp2_d, sh2_q, sh2_d, sl2_q, sl2_d;
    cnt_t       ph_q, ph_d, phs_q, phs_d;
    cnt_t       period1_q, period1_d, hi1_q, hi1_d, lo1_q, lo1_d;
    cnt_t       period2_q, period2_d, hi2_q, hi2_d, lo2_q, lo2_d, phase_q, phase_d;
    logic       cap_q, cap_d, valid_q, valid_d, locked_q, locked_d, timeout_q, timeout_d;
    logic       p1, p2, tmo, act, close;

    function automatic cnt_t inc(input cnt_t x, input logic en);
        return (en && x != '1) ? x + ONE : x;
    endfunction

    always_comb begin
        v1_d  = (V1 == 2'sb10) ? 2'b00 : V1;
        v2_d  = (V2 == 2'sb10) ? 2'b00 : V2;
        p1    = v1_q == POS && v1_p_q != POS;
        p2    = v2_q == POS && v2_p_q != POS;
        tmo   = state_q != IDLE && c1_q >= TO;
        // counters run from the acquiring P1 onwards and are wiped on timeout
        act   = !tmo && (state_q != IDLE || p1);
        c1_d  = !act ? '0 : p1 ? ONE : inc(c1_q, 1'b1);
        h1_d  = !act ? '0 : p1 ? ONE : inc(h1_q, v1_q == POS);
        l1_d  = !act ? '0 : p1 ? '0 : inc(l1_q, v1_q == NEG);
        c2_d  = !act ? '0 : p2 ? ONE : inc(c2_q, 1'b1);
        h2_d  = !act ? '0 : p2 ? ONE : inc(h2_q, v2_q == POS);
        l2_d  = !act ? '0 : p2 ? '0 : inc(l2_q, v2_q == NEG);
        n2_d  = !act ? '0 : (p2 && n2_q != 2'd2) ? n2_q + 2'd1 : n2_q;
        sp2_d = !act ? '0 : (p2 && n2_q != 2'd0) ? c2_q : sp2_q;
        sh2_d = !act ? '0 : (p2 && n2_q != 2'd0) ? h2_q : sh2_q;
        sl2_d = !act ? '0 : (p2 && n2_q != 2'd0) ? l2_q : sl2_q;
        ph_d  = !act ? '0 : p1 ? ONE : inc(ph_q, 1'b1);
        cap_d = act && (p2 || (cap_q && !p1));
        // a P2 coincident with P1 belongs to the new V1 period with phase 0
        phs_d = !act ? '0 : p1 ? '0 : (p2 && !cap_q) ? ph_q : phs_q;
        state_d   = tmo ? IDLE :
                    (p1 && state_q == IDLE) ? ACQ :
                    (p1 && state_q == ACQ) ? TRACK : state_q;
        close     = p1 && !tmo && state_q != IDLE;
        valid_d   = close && state_q == TRACK && cap_q && n2_d == 2'd2;
        locked_d  = state_d == TRACK;
        timeout_d = tmo || (timeout_q && !valid_d);
        period1_d = close ? c1_q : period1_q;
        hi1_d     = close ? h1_q : hi1_q;
        lo1_d     = close ? l1_q : lo1_q;
        period2_d = valid_d ? sp2_d : period2_q;
        hi2_d     = valid_d ? sh2_d : hi2_q;
        lo2_d     = valid_d ? sl2_d : lo2_q;
        phase_d   = valid_d ? phs_q : phase_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            v1_q      <= '0;
            v1_p_q    <= '0;
            v2_q      <= '0;
            v2_p_q    <= '0;
            n2_q      <= '0;
            c1_q      <= '0;
            h1_q      <= '0;
            l1_q      <= '0;
            c2_q      <= '0;
            h2_q      <= '0;
            l2_q      <= '0;
            sp2_q     <= '0;
            sh2_q     <= '0;
            sl2_q     <= '0;
            ph_q      <= '0;
            phs_q     <= '0;
            cap_q     <= 1'b0;
            period1_q <= '0;
            hi1_q     <= '0;
            lo1_q     <= '0;
            period2_q <= '0;
            hi2_q     <= '0;
            lo2_q     <= '0;
            phase_q   <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            v1_q      <= v1_d;
            v1_p_q    <= v1_q;
            v2_q      <= v2_d;
            v2_p_q    <= v2_q;
            n2_q      <= n2_d;
            c1_q      <= c1_d;
            h1_q      <= h1_d;
            l1_q      <= l1_d;
            c2_q      <= c2_d;
            h2_q      <= h2_d;
            l2_q      <= l2_d;
            sp2_q     <= sp2_d;
            sh2_q     <= sh2_d;
            sl2_q     <= sl2_d;
            ph_q      <= ph_d;
            phs_q     <= phs_d;
            cap_q     <= cap_d;
            period1_q <= period1_d;
            hi1_q     <= hi1_d;
            lo1_q     <= lo1_d;
            period2_q <= period2_d;
            hi2_q     <= hi2_d;
            lo2_q     <= lo2_d;
            phase_q   <= phase_d;
            valid_q   <= valid_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
        end
    end

    assign period1 = period1_q;
    assign hi1     = hi1_q;
    assign lo1     = lo1_q;
    assign period2 = period2_q;
    assign hi2     = hi2_q;
    assign lo2     = lo2_q;
    assign phase   = phase_q;
    assign valid   = valid_q;
    assign locked  = locked_q;
    assign timeout = timeout_q;
endmodule

// File: tb/tb_dab_pattern_analyzer.sv
// tb_dab_pattern_analyzer: directed and random V1/V2 patterns checked against an
// event-index reference model that recomputes each measurement from the sampled streams.
module tb_dab_pattern_analyzer;
    localparam int W  = 19;
    localparam int TO = 1000;
    localparam int N  = 40000;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic signed [1:0] V1 = '0;
    logic signed [1:0] V2 = '0;
    logic [W-1:0]      period1, hi1, lo1, period2, hi2, lo2, phase;
    logic              valid, locked, timeout;

    dab_pattern_analyzer #(.CNT_W(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .V1(V1), .V2(V2),
        .period1(period1), .hi1(hi1), .lo1(lo1),
        .period2(period2), .hi2(hi2), .lo2(lo2), .phase(phase),
        .valid(valid), .locked(locked), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int s1 [N];
    int s2 [N];
    int n = 0, rb = 0, t = 0;
    int errors = 0, checks = 0;
    int ms = 0, acq = 0, m = 0;
    int e_valid = 0, e_locked = 0, e_tmo = 0;
    int e_per1 = 0, e_hi1 = 0, e_lo1 = 0, e_per2 = 0, e_hi2 = 0, e_lo2 = 0, e_ph = 0;
    int last_valid = -1, first_valid = -1, lock_rise = -1, lock_fall = -1, saw25 = 0;
    bit prev_locked = 0;
    int per, z1, hi, z2, lo, dly, ill_lo = -1, ill_hi = -1;

    function automatic logic [1:0] enc(int v);
        return v == 1 ? 2'b01 : v == -1 ? 2'b11 : v == 2 ? 2'b10 : 2'b00;
    endfunction

    function automatic int norm(int v);
        return v == 2 ? 0 : v;
    endfunction

    function automatic bit rise1(int i);
        return s1[i] == 1 && (i == rb || s1[i-1] != 1);
    endfunction

    function automatic bit rise2(int i);
        return s2[i] == 1 && (i == rb || s2[i-1] != 1);
    endfunction

    function automatic int pat(int x);
        int p;
        p = ((x % per) + per) % per;
        return p < z1 ? 0 : p < z1 + hi ? 1 : p < z1 + hi + z2 ? 0 : -1;
    endfunction

    task automatic set_pat(int a, int b, int c, int d, int e);
        z1 = a; hi = b; z2 = c; lo = d; per = a + b + c + d; dly = e;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("valid", valid, e_valid);
        chk("locked", locked, e_locked);
        chk("timeout", timeout, e_tmo);
        chk("period1", period1, e_per1);
        chk("hi1", hi1, e_hi1);
        chk("lo1", lo1, e_lo1);
        chk("period2", period2, e_per2);
        chk("hi2", hi2, e_hi2);
        chk("lo2", lo2, e_lo2);
        chk("phase", phase, e_ph);
    endtask

    task automatic mreset();
        ms = 0; e_valid = 0; e_locked = 0; e_tmo = 0;
        e_per1 = 0; e_hi1 = 0; e_lo1 = 0; e_per2 = 0; e_hi2 = 0; e_lo2 = 0; e_ph = 0;
    endtask

    // Expected outputs one edge after sample k, derived from event positions in the streams.
    task automatic model(int k);
        e_valid = 0;
        if (ms != 0 && k - m >= TO) begin
            ms = 0; e_locked = 0; e_tmo = 1;
        end else if (rise1(k)) begin
            if (ms == 0) begin
                ms = 1; acq = k;
            end else begin
                int j, a, b, h, l;
                j = -1; a = -1; b = -1; h = 0; l = 0;
                for (int i = m; i < k; i++) begin
                    h += (s1[i] == 1) ? 1 : 0;
                    l += (s1[i] == -1) ? 1 : 0;
                    if (j < 0 && rise2(i)) j = i;
                end
                e_per1 = k - m; e_hi1 = h; e_lo1 = l;
                for (int i = acq; i <= k; i++) if (rise2(i)) begin a = b; b = i; end
                if (ms == 1) begin
                    ms = 2; e_locked = 1;
                end else if (j >= 0 && a >= 0) begin
                    e_valid = 1; e_tmo = 0; e_ph = j - m; e_per2 = b - a;
                    e_hi2 = 0; e_lo2 = 0;
                    for (int i = a; i < b; i++) begin
                        e_hi2 += (s2[i] == 1) ? 1 : 0;
                        e_lo2 += (s2[i] == -1) ? 1 : 0;
                    end
                end
            end
            m = k;
        end
    endtask

    task automatic step(int a, int b);
        V1 = enc(a); V2 = enc(b);
        s1[n] = norm(a); s2[n] = norm(b);
        @(posedge clk); #1;
        check_all();
        if (valid === 1'b1) begin
            last_valid = n;
            if (first_valid < 0) first_valid = n;
            if (hi1 == 25) saw25 = 1;
        end
        if (prev_locked && locked === 1'b0) lock_fall = n;
        if (!prev_locked && locked === 1'b1) lock_rise = n;
        prev_locked = (locked === 1'b1);
        model(n);
        n++;
    endtask

    task automatic run(int cyc);
        repeat (cyc) begin
            int a;
            a = (t >= ill_lo && t < ill_hi) ? 2 : pat(t);
            step(a, pat(t - dly));
            t++;
        end
    endtask

    task automatic hold(int cyc);
        repeat (cyc) begin
            step(0, 0);
            t++;
        end
    endtask

    initial begin
        set_pat(20, 30, 20, 30, 10);
        t = 37;
        repeat (4) begin
            V1 = enc(pat(t)); V2 = enc(pat(t - dly));
            @(posedge clk); #1;
            t++;
        end
        check_all();
        rst = 1'b1;
        run(700);
        chk("nom_period1", period1, 100);
        chk("nom_period2", period2, 100);
        chk("nom_hi1", hi1, 30);
        chk("nom_lo1", lo1, 30);
        chk("nom_hi2", hi2, 30);
        chk("nom_lo2", lo2, 30);
        chk("nom_phase", phase, 10);
        chk("acq_gap", first_valid - lock_rise, 100);

        set_pat(20, 30, 20, 30, 0);
        run(500);
        chk("zero_phase", phase, 0);
        set_pat(20, 30, 20, 30, 99);
        run(500);
        chk("wrap_phase", phase, 99);

        set_pat(20, 30, 20, 30, 10);
        run(300);
        ill_lo = t + ((145 - (t % 100)) % 100) + 100;
        ill_hi = ill_lo + 5;
        saw25 = 0;
        run(400);
        chk("illegal_hi1", saw25, 1);
        ill_lo = -1; ill_hi = -1;

        set_pat(10, 40, 10, 40, 10);
        run(500);
        chk("duty_hi1", hi1, 40);
        chk("duty_period1", period1, 100);

        set_pat(20, 30, 20, 30, 10);
        run(300);
        while (t % 100 != 50) run(1);
        lock_fall = -1;
        hold(1100);
        chk("tmo_delay", lock_fall - last_valid, TO);
        chk("tmo_flag", timeout, 1);
        run(500);
        chk("tmo_clear", timeout, 0);

        run(37);
        #1 rst = 1'b0;
        #1 mreset();
        check_all();
        #2 rst = 1'b1;
        rb = n; prev_locked = 0; first_valid = -1; lock_rise = -1;
        run(600);
        chk("reacq_gap", first_valid - lock_rise, 100);

        repeat (6) begin
            set_pat($urandom_range(0, 40), $urandom_range(1, 60), $urandom_range(0, 40),
                    $urandom_range(1, 60), 0);
            dly = $urandom_range(0, per - 1);
            run(per * 6);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
